// File: rtl/spi_cmd_defs.sv
// Shared definitions for spi_cmd_dispatch: opcodes, FSM encoding,
// status/error response field offsets and the error marker byte.
package spi_cmd_defs;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_INIT      = 8'h01;
    localparam logic [7:0] OP_WR_INV    = 8'h02;
    localparam logic [7:0] OP_RD_INV    = 8'h03;
    localparam logic [7:0] OP_WR_LEDS   = 8'h04;
    localparam logic [7:0] OP_RD_LEDS   = 8'h05;
    localparam logic [7:0] OP_WR_VEC    = 8'h06;
    localparam logic [7:0] OP_RD_VEC    = 8'h07;
    localparam logic [7:0] OP_RST_PTR   = 8'h08;
    localparam logic [7:0] OP_RD_STATUS = 8'h09;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_RESP   = 3'd2,
        ST_BURST  = 3'd3
    } state_e;

    // Status word: {zeros, err_cnt[7:0], wr_ptr[7:0]}
    localparam int STAT_PTR_LSB = 0;
    localparam int STAT_ERR_LSB = 8;

    // Error word: {zeros, ERR_MARKER, offending opcode}
    localparam int ERR_CODE_LSB = 0;
    localparam int ERR_MARK_LSB = 8;
    localparam logic [7:0] ERR_MARKER = 8'hEE;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_vec_store.sv
// Vector entry store: DEPTH x DATA_W registers, wrapping write pointer with
// explicit clear, and a combinational read port.
module spi_vec_store
    import spi_cmd_defs::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 24,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ptr_rst,
    input  logic [PTR_W-1:0]  rd_idx,
    output logic [PTR_W-1:0]  wr_ptr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            wr_ptr_d = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (ptr_rst) begin
                wr_ptr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign wr_ptr  = wr_ptr_q;
    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/spi_cmd_dispatch.sv
// SPI command dispatcher: decodes opcode/payload words into register, LED and
// vector-store accesses. Define SPI_CMD_ERR_RESP_EN to answer unknown opcodes.
module spi_cmd_dispatch
    import spi_cmd_defs::*;
#(
    parameter int PAYLOAD_W = 24,
    parameter int VEC_DEPTH = 4,
    parameter int LED_W     = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 spi_rd_data_available,
    input  logic [PAYLOAD_W+7:0] spi_rd_data,
    output logic                 spi_rd_ack,
    input  logic                 spi_wr_buffer_free,
    output logic                 spi_wr_en,
    output logic [PAYLOAD_W-1:0] spi_wr_data,
    output logic [LED_W-1:0]     led,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    localparam int WORD_W = PAYLOAD_W + 8;
    localparam int PTR_W  = $clog2(VEC_DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(VEC_DEPTH - 1);

    state_e                state_q, state_d;
    logic [7:0]            opcode_q, opcode_d;
    logic [PAYLOAD_W-1:0]  payload_q, payload_d;
    logic                  avail_seen_q, avail_seen_d;
    logic                  ack_q, ack_d;
    logic [PAYLOAD_W-1:0]  inv_q, inv_d;
    logic [LED_W-1:0]      led_q, led_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic [PTR_W-1:0]      rd_idx_q, rd_idx_d;
    logic [PAYLOAD_W-1:0]  resp_q, resp_d;

    logic                  accept;
    logic                  vec_wr_en;
    logic                  vec_clear;
    logic                  vec_ptr_rst;
    logic [PTR_W-1:0]      vec_wr_ptr;
    logic [PAYLOAD_W-1:0]  vec_rd_data;

    spi_vec_store #(
        .DEPTH  (VEC_DEPTH),
        .DATA_W (PAYLOAD_W),
        .PTR_W  (PTR_W)
    ) u_vec_store (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (vec_clear),
        .wr_en   (vec_wr_en),
        .wr_data (payload_q),
        .ptr_rst (vec_ptr_rst),
        .rd_idx  (rd_idx_q),
        .wr_ptr  (vec_wr_ptr),
        .rd_data (vec_rd_data)
    );

    // Handshake: a word is taken only in IDLE while spi_rd_data_available is
    // high and avail_seen is clear; spi_rd_ack pulses the following cycle and
    // avail_seen blocks re-taking the same word until available drops. On the
    // response side spi_wr_en is qualified by spi_wr_buffer_free in the same
    // cycle, so a strobe is never issued into a full buffer.
    always_comb begin
        accept       = (state_q == ST_IDLE) && spi_rd_data_available && !avail_seen_q;
        state_d      = state_q;
        opcode_d     = opcode_q;
        payload_d    = payload_q;
        avail_seen_d = spi_rd_data_available && (avail_seen_q || accept);
        ack_d        = accept;
        inv_d        = inv_q;
        led_d        = led_q;
        err_cnt_d    = err_cnt_q;
        rd_idx_d     = rd_idx_q;
        resp_d       = resp_q;
        vec_wr_en    = 1'b0;
        vec_clear    = 1'b0;
        vec_ptr_rst  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    opcode_d  = spi_rd_data[7:0];
                    payload_d = spi_rd_data[WORD_W-1:8];
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                resp_d  = '0;
                case (opcode_q)
                    OP_NOP: begin
                    end
                    OP_INIT: begin
                        inv_d     = '0;
                        led_d     = '0;
                        err_cnt_d = '0;
                        rd_idx_d  = '0;
                        vec_clear = 1'b1;
                    end
                    OP_WR_INV:  inv_d = ~payload_q;
                    OP_RD_INV: begin
                        resp_d  = inv_q;
                        state_d = ST_RESP;
                    end
                    OP_WR_LEDS: led_d = payload_q[LED_W-1:0];
                    OP_RD_LEDS: begin
                        resp_d[LED_W-1:0] = led_q;
                        state_d           = ST_RESP;
                    end
                    OP_WR_VEC:  vec_wr_en = 1'b1;
                    OP_RD_VEC: begin
                        rd_idx_d = '0;
                        state_d  = ST_BURST;
                    end
                    OP_RST_PTR: vec_ptr_rst = 1'b1;
                    OP_RD_STATUS: begin
                        resp_d[STAT_ERR_LSB +: 8] = err_cnt_q;
                        resp_d[STAT_PTR_LSB +: 8] = 8'(vec_wr_ptr);
                        state_d                   = ST_RESP;
                    end
                    default: begin
                        // Error word is always prepared; only the build option decides whether it is sent.
                        err_cnt_d                 = sat_inc8(err_cnt_q);
                        resp_d[ERR_MARK_LSB +: 8] = ERR_MARKER;
                        resp_d[ERR_CODE_LSB +: 8] = opcode_q;
`ifdef SPI_CMD_ERR_RESP_EN
                        state_d                   = ST_RESP;
`else
                        state_d                   = ST_IDLE;
`endif
                    end
                endcase
            end
            ST_RESP: begin
                if (spi_wr_buffer_free) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (spi_wr_buffer_free) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + PTR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            opcode_q     <= '0;
            payload_q    <= '0;
            avail_seen_q <= 1'b0;
            ack_q        <= 1'b0;
            inv_q        <= '0;
            led_q        <= '0;
            err_cnt_q    <= '0;
            rd_idx_q     <= '0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            payload_q    <= payload_d;
            avail_seen_q <= avail_seen_d;
            ack_q        <= ack_d;
            inv_q        <= inv_d;
            led_q        <= led_d;
            err_cnt_q    <= err_cnt_d;
            rd_idx_q     <= rd_idx_d;
            resp_q       <= resp_d;
        end
    end

    assign spi_rd_ack  = ack_q;
    assign spi_wr_en   = spi_wr_buffer_free && ((state_q == ST_RESP) || (state_q == ST_BURST));
    assign spi_wr_data = (state_q == ST_RESP)  ? resp_q :
                         (state_q == ST_BURST) ? vec_rd_data : '0;
    assign led         = led_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_cmd_dispatch.sv
// Self-checking bench for spi_cmd_dispatch: directed literal cases plus
// randomized commands scored against a behavioural register/vector model.
module tb_spi_cmd_dispatch;

    localparam int PW    = 24;
    localparam int DEPTH = 4;
    localparam int LW    = 3;
    localparam int W     = PW + 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          spi_rd_data_available = 1'b0;
    logic [W-1:0]  spi_rd_data = '0;
    logic          spi_rd_ack;
    logic          spi_wr_buffer_free = 1'b0;
    logic          spi_wr_en;
    logic [PW-1:0] spi_wr_data;
    logic [LW-1:0] led;
    logic          busy;
    logic [2:0]    dbg_state;

    spi_cmd_dispatch #(.PAYLOAD_W(PW), .VEC_DEPTH(DEPTH), .LED_W(LW)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .spi_rd_data_available (spi_rd_data_available),
        .spi_rd_data           (spi_rd_data),
        .spi_rd_ack            (spi_rd_ack),
        .spi_wr_buffer_free    (spi_wr_buffer_free),
        .spi_wr_en             (spi_wr_en),
        .spi_wr_data           (spi_wr_data),
        .led                   (led),
        .busy                  (busy),
        .dbg_state             (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    int ack_cnt    = 0;
    int sent_cnt   = 0;
    int free_mode  = 2;  // 0 random, 1 alternate, 2 always free, 3 never free
    logic prev_busy = 1'b0;
    logic prev_ack  = 1'b0;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] got_q[$];

    // behavioural model of the architectural state
    logic [PW-1:0] m_inv;
    logic [LW-1:0] m_led;
    logic [PW-1:0] m_vec [DEPTH];
    int            m_wp;
    int            m_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] last_got(input int k);
        if (got_q.size() > k) return got_q[got_q.size() - 1 - k];
        return 'x;
    endfunction

    task automatic model_reset();
        m_inv = '0;
        m_led = '0;
        m_wp  = 0;
        m_err = 0;
        for (int i = 0; i < DEPTH; i++) m_vec[i] = '0;
    endtask

    task automatic model_cmd(input logic [7:0] op, input logic [PW-1:0] pl);
        case (op)
            8'h00: ;
            8'h01: model_reset();
            8'h02: m_inv = ~pl;
            8'h03: exp_q.push_back(m_inv);
            8'h04: m_led = pl[LW-1:0];
            8'h05: exp_q.push_back(PW'(m_led));
            8'h06: begin
                m_vec[m_wp] = pl;
                m_wp = (m_wp + 1) % DEPTH;
            end
            8'h07: for (int i = 0; i < DEPTH; i++) exp_q.push_back(m_vec[i]);
            8'h08: m_wp = 0;
            8'h09: exp_q.push_back(PW'(m_err * 256 + m_wp));
            default: begin
                if (m_err < 255) m_err++;
`ifdef SPI_CMD_ERR_RESP_EN
                exp_q.push_back(PW'(32'h0000EE00 | 32'(op)));
`endif
            end
        endcase
    endtask

    // response buffer availability
    always @(posedge clk) begin
        #1;
        case (free_mode)
            0: spi_wr_buffer_free = 1'($urandom_range(0, 1));
            1: spi_wr_buffer_free = ~spi_wr_buffer_free;
            2: spi_wr_buffer_free = 1'b1;
            default: spi_wr_buffer_free = 1'b0;
        endcase
    end

    // scoreboard / compare process
    always @(negedge clk) begin
        if (reset_n) begin
            if (spi_wr_en) begin
                strobe_cnt++;
                got_q.push_back(spi_wr_data);
                check("wr_en_while_not_free", {31'd0, spi_wr_buffer_free}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got 0x%0h, no response expected", spi_wr_data);
                end else begin
                    check("wr_data", {8'd0, spi_wr_data}, {8'd0, exp_q.pop_front()});
                end
            end
            if (spi_rd_ack) begin
                ack_cnt++;
                check("ack_while_busy", {31'd0, prev_busy}, 32'd0);
                check("ack_pulse_width", {31'd0, prev_ack}, 32'd0);
                check("busy_in_decode", {31'd0, busy}, 32'd1);
            end
        end
        prev_busy = busy;
        prev_ack  = spi_rd_ack;
    end

    // driver tasks
    task automatic send(input logic [7:0] op, input logic [PW-1:0] pl);
        int t = 0;
        @(posedge clk);
        #1;
        spi_rd_data           = {pl, op};
        spi_rd_data_available = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!spi_rd_ack && t < 400);
        n_checks++;
        if (!spi_rd_ack) begin
            n_fail++;
            $display("FAIL ack_timeout: op 0x%0h not acked after %0d cycles", op, t);
            spi_rd_data_available = 1'b0;
            return;
        end
        sent_cnt++;
        check("led_before_write", {29'd0, led}, {29'd0, m_led});
        model_cmd(op, pl);
        @(posedge clk);
        #1;
        spi_rd_data_available = 1'b0;
        @(negedge clk);
        check("led_after_write", {29'd0, led}, {29'd0, m_led});
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || exp_q.size() != 0) && t < 600) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (busy || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b pending=%0d", busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int s0;
        int t;
        logic [7:0] op;

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_rd_ack", {31'd0, spi_rd_ack}, 32'd0);
        check("rst_wr_en", {31'd0, spi_wr_en}, 32'd0);
        check("rst_wr_data", {8'd0, spi_wr_data}, 32'd0);
        check("rst_led", {29'd0, led}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // inversion register
        send(8'h02, 24'h00F0F0);
        send(8'h03, 24'h0);
        wait_idle();
        check("rd_inv_literal", {8'd0, last_got(0)}, 32'h00FF0F0F);
        check("ack_count_two", ack_cnt, 2);

        // LEDs
        send(8'h04, 24'h000005);
        check("led_literal", {29'd0, led}, 32'd5);
        send(8'h05, 24'h0);
        wait_idle();
        check("rd_leds_literal", {8'd0, last_got(0)}, 32'd5);

        // vector wrap
        for (int v = 1; v <= 5; v++) send(8'h06, PW'(v));
        send(8'h07, 24'h0);
        wait_idle();
        check("rd_vec_e0", {8'd0, last_got(3)}, 32'd5);
        check("rd_vec_e1", {8'd0, last_got(2)}, 32'd2);
        check("rd_vec_e2", {8'd0, last_got(1)}, 32'd3);
        check("rd_vec_e3", {8'd0, last_got(0)}, 32'd4);
        send(8'h09, 24'h0);
        wait_idle();
        check("status_after_wrap", {8'd0, last_got(0)}, 32'h000001);

        // throttled burst with a word held off mid-burst
        free_mode = 1;
        s0 = strobe_cnt;
        send(8'h07, 24'h0);
        send(8'h04, 24'h000002);
        wait_idle();
        check("burst_strobe_count", strobe_cnt - s0, 4);
        check("held_word_led", {29'd0, led}, 32'd2);

        // unknown opcode
        free_mode = 0;
        s0 = strobe_cnt;
        send(8'h3C, 24'h0);
        wait_idle();
`ifdef SPI_CMD_ERR_RESP_EN
        check("err_resp_strobes", strobe_cnt - s0, 1);
        check("err_resp_literal", {8'd0, last_got(0)}, 32'h00EE3C);
`else
        check("err_no_strobe", strobe_cnt - s0, 0);
`endif
        send(8'h09, 24'h0);
        wait_idle();
        check("status_err1", {8'd0, last_got(0)}, 32'h000101);
        send(8'h01, 24'h0);
        send(8'h09, 24'h0);
        wait_idle();
        check("status_after_init", {8'd0, last_got(0)}, 32'h000000);

        // err_cnt saturation
        free_mode = 2;
        for (int i = 0; i < 260; i++) send(8'($urandom_range(8'h0A, 8'hFF)), PW'($urandom));
        wait_idle();
        send(8'h09, 24'h0);
        wait_idle();
        check("status_saturated", {8'd0, last_got(0)}, 32'h00FF00);

        // randomized commands against the model
        for (int i = 0; i < 200; i++) begin
            free_mode = $urandom_range(0, 2);
            t = $urandom_range(0, 11);
            if (t == 10) op = 8'($urandom_range(8'h0A, 8'hFF));
            else if (t == 11) op = 8'h06;
            else op = 8'(t);
            send(op, PW'($urandom));
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        free_mode = 2;
        wait_idle();

        // reset in the middle of a burst
        send(8'h01, 24'h0);
        for (int v = 0; v < DEPTH; v++) send(8'h06, PW'(24'hA00000 + v));
        send(8'h09, 24'h0);
        wait_idle();
        check("status_ptr_wrapped", {8'd0, last_got(0)}, 32'h000000);
        send(8'h04, 24'h000007);
        free_mode = 1;
        s0 = strobe_cnt;
        send(8'h07, 24'h0);
        t = 0;
        while (strobe_cnt == s0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("burst_started", {31'd0, 1'(strobe_cnt > s0)}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_rd_ack", {31'd0, spi_rd_ack}, 32'd0);
        check("abort_wr_en", {31'd0, spi_wr_en}, 32'd0);
        check("abort_wr_data", {8'd0, spi_wr_data}, 32'd0);
        check("abort_led", {29'd0, led}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        model_reset();
        free_mode = 2;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        s0 = strobe_cnt;
        repeat (10) @(negedge clk);
        check("no_strobe_after_reset", strobe_cnt - s0, 0);
        send(8'h07, 24'h0);
        wait_idle();
        for (int k = 0; k < DEPTH; k++) check("vec_zero_after_reset", {8'd0, last_got(k)}, 32'd0);

        check("ack_per_word", ack_cnt, sent_cnt);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
